// File: rtl/and_unit_tester.sv
// Built-in exhaustive self-test driver and checker for the bitwise-AND unit.
// It sweeps every {a,b} operand pair, counts mismatches and keeps the first failing vector.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | operands parked at zero, results held, waiting for start
//   ST_RUN  | driving vector idx, comparing c_in once per SETTLE cycles
//   ST_DONE | one-cycle end-of-sweep marker, pass flag valid
module and_unit_tester #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH-1:0]     c_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [2*WIDTH-1:0]   first_fail
);

    localparam int         IW          = 2 * WIDTH;
    localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_cnt;
    logic [7:0]      r_err;
    logic [IW-1:0]   r_first;
    logic            r_pass;

    logic            w_cmp;
    logic            w_mismatch;
    logic            w_last_vec;
    logic [7:0]      w_err_nxt;

    // idx is zero whenever the sweep is not running (reset, start load and the
    // wrap after the all-ones vector), so it doubles as the registered operand bus.
    assign a_out      = r_idx[IW-1:WIDTH];
    assign b_out      = r_idx[WIDTH-1:0];
    assign err_count  = r_err;
    assign first_fail = r_first;
    assign pass       = r_pass;

    assign w_cmp      = (r_state == ST_RUN) && (r_cnt == LP_CNT_LAST);
    assign w_mismatch = (c_in != (a_out & b_out));
    assign w_last_vec = &r_idx;
    assign w_err_nxt  = (w_mismatch && (r_err != 8'hFF)) ? (r_err + 8'd1) : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_cmp && w_last_vec) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_cnt   <= 8'd0;
            r_err   <= 8'd0;
            r_first <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_cnt   <= 8'd0;
                        r_err   <= 8'd0;
                        r_first <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_cmp) begin
                        r_cnt <= 8'd0;
                        r_idx <= r_idx + IW'(1);
                        r_err <= w_err_nxt;
                        if (w_mismatch && (r_err == 8'd0)) begin
                            r_first <= r_idx;
                        end
                        if (w_last_vec) begin
                            r_pass <= (w_err_nxt == 8'd0);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_and_unit_tester.sv
// Bench for and_unit_tester: a fault-injecting AND-unit model feeds c_in, a
// per-sweep reference model fills a scoreboard that a negedge monitor drains at each done.
module tb_and_unit_tester;

    localparam int W  = 4;
    localparam int S  = 3;
    localparam int NV = 1 << (2 * W);

    typedef struct {
        logic       p;
        logic [7:0] e;
        logic [7:0] f;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_out, b_out, c_in;
    logic           busy, done, pass;
    logic [7:0]     err_count;
    logic [2*W-1:0] first_fail;

    logic           start2 = 1'b0;
    logic [1:0]     a2, b2, c2;
    logic           busy2, done2, pass2;
    logic [7:0]     err2;
    logic [3:0]     first2;

    always #5 clk = ~clk;

    and_unit_tester #(.WIDTH(W), .SETTLE(S)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out), .c_in(c_in),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail)
    );

    and_unit_tester #(.WIDTH(2), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_out(a2), .b_out(b2), .c_in(c2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(first2)
    );

    // Second unit: an OR gate standing in for the AND unit, purely combinational.
    assign c2 = a2 | b2;

    // Fault table: xor mask applied to the ideal result for each {a,b}.
    logic [W-1:0]   ft [NV];
    logic [2*W-1:0] prev1 = '0;
    logic [2*W-1:0] prev2 = '0;

    always @(posedge clk) begin
        prev1 <= {a_out, b_out};
        prev2 <= prev1;
    end

    // Result is garbage until operands have been stable for SETTLE-1 cycles.
    always_comb begin
        logic [W-1:0] f;
        f    = (a_out & b_out) ^ ft[{a_out, b_out}];
        c_in = (({a_out, b_out} == prev1) && (prev1 == prev2)) ? f : ~f;
    end

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic set_mode(input int m);
        for (int v = 0; v < NV; v++) begin
            logic [2*W-1:0] vv;
            logic [W-1:0]   a, b, ab;
            vv = (2*W)'(v);
            a  = vv[2*W-1:W];
            b  = vv[W-1:0];
            ab = a & b;
            case (m)
                1:       ft[v] = ab[0] ? '0 : W'(1);
                2:       ft[v] = '1;
                3:       ft[v] = ($urandom_range(0, 15) == 0) ? W'($urandom_range(1, 15)) : '0;
                4:       ft[v] = (a | b) ^ ab;
                default: ft[v] = '0;
            endcase
        end
    endtask

    // Reference: walk all vectors in order, count results that differ from a & b.
    function automatic exp_t model();
        exp_t r;
        int   cnt;
        bit   got;
        cnt = 0;
        got = 0;
        r.f = '0;
        for (int v = 0; v < NV; v++) begin
            logic [2*W-1:0] vv;
            logic [W-1:0]   a, b, c;
            vv = (2*W)'(v);
            a  = vv[2*W-1:W];
            b  = vv[W-1:0];
            c  = (a & b) ^ ft[v];
            if (c != (a & b)) begin
                cnt++;
                if (!got) begin
                    got = 1;
                    r.f = vv;
                end
            end
        end
        r.e = (cnt > 255) ? 8'd255 : 8'(cnt);
        r.p = (cnt == 0);
        return r;
    endfunction

    // Monitor: checks operand sequence while busy and drains the scoreboard on done.
    initial begin
        int   busy_len;
        int   vec_bad;
        logic done_d;
        exp_t e;
        busy_len = 0;
        vec_bad  = 0;
        done_d   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_len = 0;
                vec_bad  = 0;
            end else begin
                if (busy) begin
                    if ({a_out, b_out} != (2*W)'(busy_len / S)) vec_bad++;
                    busy_len++;
                end
                if (done) begin
                    chk("done_one_cycle", done_d, 1'b0);
                    if (sb.size() == 0) begin
                        chk("done_expected", 1'b0, 1'b1);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_pass", pass, e.p);
                        chk("sb_err_count", err_count, e.e);
                        chk("sb_first_fail", first_fail, e.f);
                        chk("sb_busy_len", busy_len, NV * S);
                        chk("sb_vec_seq_errors", vec_bad, 0);
                        chk("done_ops_zero", {a_out, b_out}, 0);
                        chk("done_busy_low", busy, 1'b0);
                    end
                    busy_len = 0;
                    vec_bad  = 0;
                end
            end
            done_d = done;
        end
    end

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 4 * NV * S; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_sweep(input int m);
        exp_t e;
        bit   ok;
        set_mode(m);
        e = model();
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        chk("sweep_finished", ok, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_err_count", err_count, e.e);
        chk("hold_first_fail", first_fail, e.f);
        chk("hold_pass", pass, e.p);
        chk("hold_busy_low", busy, 1'b0);
        if (m == 2) chk("saturated_err", err_count, 8'd255);
    endtask

    initial begin
        bit ok;
        int seen;
        int blen;
        exp_t e;

        set_mode(0);
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_busy", busy, 1'b0);
            chk("rst_outputs", {a_out, b_out, done, pass, err_count, first_fail}, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run_sweep(0);
        run_sweep(1);
        run_sweep(2);
        run_sweep(4);
        run_sweep(3);
        run_sweep(3);
        run_sweep(0);

        // start held high: one sweep, then restart right after DONE, aborted at vector 5.
        set_mode(1);
        e = model();
        sb.push_back(e);
        sb.push_back(e);
        start = 1'b1;
        wait_done(ok);
        chk("held_start_done", ok, 1'b1);
        @(negedge clk);
        chk("idle_gap_busy", busy, 1'b0);
        @(negedge clk);
        chk("restart_busy", busy, 1'b1);
        repeat (15) @(negedge clk);
        chk("at_vector5", {a_out, b_out}, 5);
        chk("err_before_abort", err_count, 8'd5);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err_count, 8'd0);
        chk("abort_ops", {a_out, b_out, first_fail, pass}, 0);
        sb.delete();
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_done_after_abort", seen, 0);

        // OR-instead-of-AND on the 2-bit, single-cycle-settle instance.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        blen = 0;
        ok   = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy2) blen++;
            @(negedge clk);
            if (done2) begin
                ok = 1;
                break;
            end
        end
        chk("or_done", ok, 1'b1);
        chk("or_busy_len", blen, 16);
        chk("or_err_count", err2, 8'd12);
        chk("or_first_fail", first2, 4'b0001);
        chk("or_pass", pass2, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
